// File: rtl/sine_bram_pkg.sv
// Shared types, constants and the quarter-wave sine preload table for sine_bram.
package sine_bram_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 11;
    localparam int unsigned QSINE_LEN  = 64;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    // round(1023*sin(pi*i/126)), i = 0..63. Entry 21 is sin(pi/6) evaluated in double
    // precision (511.4999...), hence 511.
    localparam data_t QSINE [0:QSINE_LEN-1] = '{
        11'd0,    11'd26,   11'd51,   11'd76,   11'd102,  11'd127,  11'd152,  11'd178,
        11'd203,  11'd228,  11'd252,  11'd277,  11'd302,  11'd326,  11'd350,  11'd374,
        11'd397,  11'd421,  11'd444,  11'd467,  11'd489,  11'd511,  11'd533,  11'd555,
        11'd576,  11'd597,  11'd618,  11'd638,  11'd658,  11'd677,  11'd696,  11'd714,
        11'd732,  11'd750,  11'd767,  11'd784,  11'd800,  11'd815,  11'd831,  11'd845,
        11'd859,  11'd873,  11'd886,  11'd898,  11'd910,  11'd922,  11'd932,  11'd943,
        11'd952,  11'd961,  11'd970,  11'd978,  11'd985,  11'd991,  11'd997,  11'd1003,
        11'd1007, 11'd1012, 11'd1015, 11'd1018, 11'd1020, 11'd1022, 11'd1023, 11'd1023
    };

endpackage

// File: rtl/sine_bram_if.sv
// Port-A bus of the sine table RAM: enable, write enable, address, data in/out.
interface sine_bram_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 11
);
    logic              ena;
    logic [0:0]        wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (
        output ena,
        output wea,
        output addra,
        output dina,
        input  douta
    );

    modport slave (
        input  ena,
        input  wea,
        input  addra,
        input  dina,
        output douta
    );
endinterface

// File: rtl/sine_bram_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the clock.
module sine_bram_rst_sync (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rst
);
    logic [1:0] r_sync;

    // Shift zeros in once reset is gone; any reset assertion sets both flops at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], 1'b0};
        end
    end

    assign o_rst = r_sync[1];
endmodule

// File: rtl/sine_bram.sv
// Single-port 2**ADDR_W x DATA_W block RAM preloaded with a quarter-wave sine table,
// write-first, registered read. Define SINE_BRAM_DOUT_REG_EN for an extra output
// register (read latency 2).
module sine_bram
    import sine_bram_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter string       INIT_FILE = ""
) (
    input logic        clka,
    input logic        rsta,
    sine_bram_if.slave port_a
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout_arr;
    logic              w_rst_int;
    logic              w_access;
    logic              w_write;

    sine_bram_rst_sync u_rst_sync (
        .i_clk (clka),
        .i_rst (rsta),
        .o_rst (w_rst_int)
    );

    // Accesses stay blocked until the synchronised reset has released.
    assign w_access = port_a.ena && !w_rst_int;
    assign w_write  = w_access && port_a.wea[0];

    // Preload: built-in quarter wave, zero elsewhere.
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < QSINE_LEN) begin
                r_mem[i] = DATA_W'(QSINE[i]);
            end else begin
                r_mem[i] = '0;
            end
        end
    end

    // Array write port; contents are never touched by reset.
    always_ff @(posedge clka) begin
        if (w_write) begin
            r_mem[port_a.addra] <= port_a.dina;
        end
    end

    // Array read register, write-first; cleared immediately by rsta.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_dout_arr <= '0;
        end else if (w_access) begin
            r_dout_arr <= port_a.wea[0] ? port_a.dina : r_mem[port_a.addra];
        end
    end

`ifdef SINE_BRAM_DOUT_REG_EN
    logic [DATA_W-1:0] r_dout_out;

    // Optional output stage, advancing only on enabled cycles.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_dout_out <= '0;
        end else if (w_access) begin
            r_dout_out <= r_dout_arr;
        end
    end

    assign port_a.douta = r_dout_out;
`else
    assign port_a.douta = r_dout_arr;
`endif

endmodule

// File: tb/tb_sine_bram.sv
// Scoreboard bench for sine_bram: stimulus pushes expected read data, a monitor pops and
// compares whenever the RAM presents a fresh result.
module tb_sine_bram;

    localparam int GAP = 2;

    // Hand-computed round(1023*sin(pi*i/126)); entry 21 taken as 511 (double precision).
    localparam logic [10:0] QS [64] = '{
        11'd0,    11'd26,   11'd51,   11'd76,   11'd102,  11'd127,  11'd152,  11'd178,
        11'd203,  11'd228,  11'd252,  11'd277,  11'd302,  11'd326,  11'd350,  11'd374,
        11'd397,  11'd421,  11'd444,  11'd467,  11'd489,  11'd511,  11'd533,  11'd555,
        11'd576,  11'd597,  11'd618,  11'd638,  11'd658,  11'd677,  11'd696,  11'd714,
        11'd732,  11'd750,  11'd767,  11'd784,  11'd800,  11'd815,  11'd831,  11'd845,
        11'd859,  11'd873,  11'd886,  11'd898,  11'd910,  11'd922,  11'd932,  11'd943,
        11'd952,  11'd961,  11'd970,  11'd978,  11'd985,  11'd991,  11'd997,  11'd1003,
        11'd1007, 11'd1012, 11'd1015, 11'd1018, 11'd1020, 11'd1022, 11'd1023, 11'd1023
    };

    typedef struct {
        logic [10:0] exp;
        bit          neg;
        int          tag;
    } sb_item_t;

    logic clka;
    logic rsta;
    logic tb_track;
    logic tb_s1;
    logic tb_new;
    int   n_tests;
    int   n_fail;
    sb_item_t sb_q [$];

    sine_bram_if #(.ADDR_W(8), .DATA_W(11)) bus ();

    sine_bram dut (
        .clka   (clka),
        .rsta   (rsta),
        .port_a (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // Marks the edge at which a tracked result becomes visible on douta.
    always @(posedge clka or posedge rsta) begin
        if (rsta) begin
            tb_s1  <= 1'b0;
            tb_new <= 1'b0;
        end else begin
`ifdef SINE_BRAM_DOUT_REG_EN
            if (bus.ena) begin
                tb_s1  <= tb_track;
                tb_new <= tb_s1;
            end else begin
                tb_new <= 1'b0;
            end
`else
            tb_new <= bus.ena && tb_track;
`endif
        end
    end

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: douta=0x%03h (%0d) expected 0x%03h (%0d)", name, act, act, exp,
                     exp);
        end
    endtask

    task automatic check_neg(input string name, input logic [10:0] act, input logic [10:0] exp);
        logic signed [11:0] na;
        logic signed [11:0] ne;
        na = -$signed({1'b0, act});
        ne = -$signed({1'b0, exp});
        n_tests++;
        if (na !== ne) begin
            n_fail++;
            $display("FAIL %s: negated=%0d expected %0d", name, na, ne);
        end
    endtask

    // Monitor: compares each fresh output against the oldest expectation.
    always @(negedge clka) begin
        if (tb_new) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: douta=0x%03h with no expected entry", bus.douta);
            end else begin
                sb_item_t it;
                it = sb_q.pop_front();
                check($sformatf("sb_addr[%0d]", it.tag), bus.douta, it.exp);
                if (it.neg) check_neg($sformatf("sb_neg[%0d]", it.tag), bus.douta, it.exp);
            end
        end
    end

    task automatic drive(input logic en, input logic we, input logic [7:0] a,
                         input logic [10:0] d, input logic trk);
        @(negedge clka);
        bus.ena   = en;
        bus.wea   = we;
        bus.addra = a;
        bus.dina  = d;
        tb_track  = trk;
    endtask

    task automatic push(input logic [10:0] e, input bit n, input int a);
        sb_item_t it;
        it.exp = e;
        it.neg = n;
        it.tag = a;
        sb_q.push_back(it);
    endtask

    task automatic rd(input logic [7:0] a, input logic [10:0] e, input bit n);
        drive(1'b1, 1'b0, a, 11'h000, 1'b1);
        push(e, n, int'(a));
    endtask

    task automatic wr(input logic [7:0] a, input logic [10:0] d, input logic [10:0] e);
        drive(1'b1, 1'b1, a, d, 1'b1);
        push(e, 1'b0, int'(a));
    endtask

    // Untracked enabled read: pushes the last tracked result through an output stage.
    task automatic flush(input logic [7:0] a);
        drive(1'b1, 1'b0, a, 11'h000, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00, 11'h000, 1'b0);
    endtask

    initial begin
        logic [31:0] wide;
        n_tests   = 0;
        n_fail    = 0;
        rsta      = 1'b1;
        tb_track  = 1'b0;
        bus.ena   = 1'b0;
        bus.wea   = 1'b0;
        bus.addra = 8'h00;
        bus.dina  = 11'h000;

        idle(3);
        #1 check("reset_dout", bus.douta, 11'd0);
        #1 rsta = 1'b0;
        idle(3);
        #1 check("release_dout", bus.douta, 11'd0);

        // Preloaded contents, including an address past the quarter wave.
        rd(8'd0, 11'd0, 1'b0);
        rd(8'd32, 11'd732, 1'b0);
        rd(8'd63, 11'd1023, 1'b0);
        rd(8'd100, 11'd0, 1'b0);
        flush(8'd100);

        // Reset pulse between two edges clears douta without a clock.
        rd(8'd32, 11'd732, 1'b0);
        flush(8'd32);
        idle(1);
        #1 check("pre_pulse", bus.douta, 11'd732);
        #1 rsta = 1'b1;
        sb_q.delete();
        #1 check("pulse_async", bus.douta, 11'd0);
        #1 rsta = 1'b0;
        idle(3);
        #1 check("pulse_release", bus.douta, 11'd0);

        // Ascending sweep, interrupted by a reset that also tries to write mem[41].
        for (int i = 0; i < 40; i++) begin
            rd(8'(i), QS[i], 1'b1);
            idle(GAP);
        end
        rd(8'd40, QS[40], 1'b1);
        #2 rsta = 1'b1;
        sb_q.delete();
        #1 check("midrst_async", bus.douta, 11'd0);
        drive(1'b1, 1'b1, 8'd41, 11'h000, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 11'h000, 1'b0);
        #1 check("midrst_hold", bus.douta, 11'd0);
        #1 rsta = 1'b0;
        idle(3);
        for (int i = 40; i < 64; i++) begin
            rd(8'(i), QS[i], 1'b1);
            idle(GAP);
        end
        for (int i = 63; i >= 0; i--) begin
            rd(8'(i), QS[i], 1'b1);
            idle(GAP);
        end
        flush(8'd0);

        // Write-first, read-back, and truncation of a wide driver.
        wr(8'd5, 11'h155, 11'h155);
        rd(8'd5, 11'h155, 1'b0);
        wide = 32'hFFFF_F9AB;
        wr(8'd5, wide[10:0], 11'h1AB);
        rd(8'd5, 11'h1AB, 1'b0);
        flush(8'd5);

        // Disabled port: write request ignored and output held.
        rd(8'd32, 11'd732, 1'b0);
        flush(8'd32);
        drive(1'b0, 1'b1, 8'd7, 11'h3FF, 1'b0);
        idle(1);
        #1 check("ena_hold", bus.douta, 11'd732);
        rd(8'd7, 11'd178, 1'b0);
        flush(8'd7);
        idle(3);

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected entries never seen, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
